// File: rtl/pitch_tracker.sv
// Pitch tracker: hysteretic zero-crossing period measurement, windowed averaging,
// and semitone/octave classification with a stability hold before reporting.
module pitch_tracker #(
    parameter int unsigned clk_mhz   = 50,
    parameter int unsigned W_MIC     = 24,
    parameter int unsigned W_CNT     = 20,
    parameter int unsigned HYST      = 16,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned TOL_PCT   = 3,
    parameter int unsigned N_OCT     = 3,
    parameter int unsigned HOLD_LOG2 = 20
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic signed [W_MIC-1:0]                    mic,
    output logic                                       note_vld,
    output logic [3:0]                                 note_idx,
    output logic [((N_OCT > 1) ? $clog2(N_OCT) : 1)-1:0] note_oct,
    output logic                                       note_chg,
    output logic [W_CNT-1:0]                           period_avg
);

    localparam int unsigned OW    = (N_OCT > 1) ? $clog2(N_OCT) : 1;
    localparam int unsigned NPW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned W_ACC = W_CNT + AVG_LOG2;
    localparam int unsigned N_CLS = 12 * N_OCT;

    localparam logic signed [W_MIC-1:0] HYST_POS = W_MIC'(HYST);
    localparam logic signed [W_MIC-1:0] HYST_NEG = -HYST_POS;
    localparam logic [W_CNT-1:0]        CNT_SAT  = '1;
    localparam logic [NPW-1:0]          LAST_PER = NPW'(2 ** AVG_LOG2 - 1);
    localparam logic [HOLD_LOG2-1:0]    HOLD_MAX = '1;

    // ------------------------------------------------------------------
    // Crossing detector
    // ------------------------------------------------------------------
    typedef enum logic {
        SEEK_NEG = 1'b0,
        SEEK_POS = 1'b1
    } xing_state_t;

    xing_state_t state, state_nxt;
    logic        xing;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEEK_NEG;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEEK_NEG: if (mic <= HYST_NEG) state_nxt = SEEK_POS;
            SEEK_POS: if (mic >= HYST_POS) state_nxt = SEEK_NEG;
            default:  state_nxt = SEEK_NEG;
        endcase
    end

    always_comb begin
        xing = (state == SEEK_POS) && (mic >= HYST_POS);
    end

    // ------------------------------------------------------------------
    // Period counter and averaging window
    // ------------------------------------------------------------------
    logic [W_CNT-1:0] cnt;
    logic [W_CNT-1:0] cnt_inc;
    logic             silent;
    logic             first_seen;
    logic [W_ACC-1:0] acc;
    logic [W_ACC-1:0] acc_sum;
    logic [NPW-1:0]   n_per;
    logic             win_bad_acc;
    logic             per_sat;
    logic             win_done;
    logic             win_bad;

    // The recorded period includes the crossing cycle itself, so a wave with
    // crossings N cycles apart measures exactly N.
    always_comb begin
        cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
        silent  = (cnt == CNT_SAT);
        per_sat = (cnt_inc == CNT_SAT);
        acc_sum = acc + W_ACC'(cnt_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            first_seen  <= 1'b0;
            acc         <= '0;
            n_per       <= '0;
            win_bad_acc <= 1'b0;
            win_done    <= 1'b0;
            win_bad     <= 1'b0;
            period_avg  <= '0;
        end else begin
            win_done <= 1'b0;
            if (xing) begin
                cnt <= '0;
                if (!first_seen) begin
                    first_seen <= 1'b1;
                end else if (n_per == LAST_PER) begin
                    period_avg  <= W_CNT'(acc_sum >> AVG_LOG2);
                    win_done    <= 1'b1;
                    win_bad     <= win_bad_acc | per_sat;
                    acc         <= '0;
                    n_per       <= '0;
                    win_bad_acc <= 1'b0;
                end else begin
                    acc         <= acc_sum;
                    n_per       <= n_per + 1'b1;
                    win_bad_acc <= win_bad_acc | per_sat;
                end
            end else if (silent) begin
                first_seen  <= 1'b0;
                acc         <= '0;
                n_per       <= '0;
                win_bad_acc <= 1'b0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification against elaboration-time period bands
    // ------------------------------------------------------------------
    function automatic longint unsigned f100(input int unsigned n);
        case (n)
            0:       return 64'd26163;
            1:       return 64'd27718;
            2:       return 64'd29366;
            3:       return 64'd31113;
            4:       return 64'd32963;
            5:       return 64'd34923;
            6:       return 64'd36999;
            7:       return 64'd39200;
            8:       return 64'd41530;
            9:       return 64'd44000;
            10:      return 64'd46616;
            default: return 64'd49388;
        endcase
    endfunction

    function automatic longint unsigned nominal(input int unsigned n, input int unsigned k);
        return (64'(clk_mhz) * 64'd100_000_000) / (f100(n) << k);
    endfunction

    logic [63:0]      avg64;
    logic [N_CLS-1:0] match;

    always_comb begin
        avg64 = 64'(period_avg);
    end

    for (genvar g = 0; g < N_CLS; g++) begin : g_cls
        localparam longint unsigned P  = nominal(g % 12, g / 12);
        localparam longint unsigned LO = P * (100 - TOL_PCT) / 100;
        localparam longint unsigned HI = P * (100 + TOL_PCT) / 100;
        assign match[g] = (avg64 > LO) && (avg64 < HI);
    end

    logic          cls_hit;
    logic [3:0]    cls_idx;
    logic [OW-1:0] cls_oct;

    // Index order is octave-major, so the first hit is lowest octave, then lowest note.
    always_comb begin
        cls_hit = 1'b0;
        cls_idx = '0;
        cls_oct = '0;
        for (int unsigned i = 0; i < N_CLS; i++) begin
            if (match[i] && !cls_hit) begin
                cls_hit = 1'b1;
                cls_idx = 4'(i % 12);
                cls_oct = OW'(i / 12);
            end
        end
    end

    // ------------------------------------------------------------------
    // Candidate register and stability hold
    // ------------------------------------------------------------------
    logic                 cand_vld, cand_vld_nxt;
    logic [3:0]           cand_idx, cand_idx_nxt;
    logic [OW-1:0]        cand_oct, cand_oct_nxt;
    logic                 cand_chg;
    logic [HOLD_LOG2-1:0] hold_cnt;

    always_comb begin
        cand_vld_nxt = cand_vld;
        cand_idx_nxt = cand_idx;
        cand_oct_nxt = cand_oct;
        if (silent || (win_done && (win_bad || !cls_hit))) begin
            cand_vld_nxt = 1'b0;
            cand_idx_nxt = '0;
            cand_oct_nxt = '0;
        end else if (win_done) begin
            cand_vld_nxt = 1'b1;
            cand_idx_nxt = cls_idx;
            cand_oct_nxt = cls_oct;
        end
        cand_chg = {cand_vld_nxt, cand_idx_nxt, cand_oct_nxt} != {cand_vld, cand_idx, cand_oct};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_vld <= 1'b0;
            cand_idx <= '0;
            cand_oct <= '0;
            hold_cnt <= '0;
        end else begin
            cand_vld <= cand_vld_nxt;
            cand_idx <= cand_idx_nxt;
            cand_oct <= cand_oct_nxt;
            if (cand_chg) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            note_vld <= 1'b0;
            note_idx <= '0;
            note_oct <= '0;
            note_chg <= 1'b0;
        end else begin
            note_chg <= 1'b0;
            if (hold_cnt == HOLD_MAX) begin
                note_vld <= cand_vld;
                note_idx <= cand_idx;
                note_oct <= cand_oct;
                note_chg <= {cand_vld, cand_idx, cand_oct} != {note_vld, note_idx, note_oct};
            end
        end
    end

endmodule

// File: tb/tb_pitch_tracker.sv
// Bench for pitch_tracker: randomized square waves checked cycle-by-cycle against a
// timestamp-based reference model, plus a note table and hand-written corner sequences.
module tb_pitch_tracker;

    localparam int W_CNT = 13;
    localparam int HYST  = 16;
    localparam int SAT   = (1 << W_CNT) - 1;
    localparam int HMAX  = 15;
    localparam int F100[12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                                36999, 39200, 41530, 44000, 46616, 49388};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [23:0] mic = '0;
    logic              note_vld;
    logic [3:0]        note_idx;
    logic [1:0]        note_oct;
    logic              note_chg;
    logic [W_CNT-1:0]  period_avg;

    always #5 clk = ~clk;

    pitch_tracker #(
        .clk_mhz(1), .W_MIC(24), .W_CNT(W_CNT), .HYST(HYST), .AVG_LOG2(2),
        .TOL_PCT(3), .N_OCT(3), .HOLD_LOG2(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mic(mic), .note_vld(note_vld), .note_idx(note_idx),
        .note_oct(note_oct), .note_chg(note_chg), .period_avg(period_avg)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    longint      t        = 0;
    int          chg_cnt  = 0;
    longint      t0       = 0;
    longint      first_avg = -1;

    // Reference model: crossings by timestamp, periods in a queue, notes as k*12+n (-1 = none)
    bit     m_armed, m_have_ref, m_wd, m_wbad, m_chg;
    longint m_ref_t;
    int     m_q[$];
    int     m_avg, m_cand, m_hold, m_out;

    function automatic int classify(input int avg);
        longint p, lo, hi;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 12; n++) begin
                p  = 64'd100000000 / (longint'(F100[n]) << k);
                lo = p * 97 / 100;
                hi = p * 103 / 100;
                if (avg > lo && avg < hi) return k * 12 + n;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input int s, input bit r);
        bit x, sat, nbad;
        int nc, p, sum;
        if (!r) begin
            m_armed = 0; m_ref_t = t; m_have_ref = 0; m_q.delete();
            m_avg = 0; m_wd = 0; m_wbad = 0; m_cand = -1; m_hold = 0; m_out = -1; m_chg = 0;
            return;
        end
        m_chg = 0;
        if (m_hold == HMAX) begin
            m_chg = (m_cand != m_out);
            m_out = m_cand;
        end
        sat = (t - m_ref_t - 1) >= SAT;
        nc  = m_cand;
        if (sat) nc = -1;
        else if (m_wd) nc = m_wbad ? -1 : classify(m_avg);
        m_hold = (nc != m_cand) ? 0 : ((m_hold < HMAX) ? m_hold + 1 : HMAX);
        m_cand = nc;
        x = 0;
        if (!m_armed) begin
            if (s <= -HYST) m_armed = 1;
        end else if (s >= HYST) begin
            x = 1;
            m_armed = 0;
        end
        m_wd = 0;
        if (x) begin
            if (m_have_ref) begin
                p = (t - m_ref_t >= SAT) ? SAT : int'(t - m_ref_t);
                m_q.push_back(p);
                if (m_q.size() == 4) begin
                    sum = 0; nbad = 0;
                    foreach (m_q[i]) begin
                        sum += m_q[i];
                        if (m_q[i] == SAT) nbad = 1;
                    end
                    m_avg = sum / 4; m_wd = 1; m_wbad = nbad;
                    m_q.delete();
                end
            end
            m_have_ref = 1;
            m_ref_t = t;
        end else if (sat) begin
            m_have_ref = 0;
            m_q.delete();
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, t);
    endtask

    task automatic tick(input int s, input bit r);
        logic [20:0] e, a;
        mic   = 24'(s);
        rst_n = r;
        @(posedge clk);
        model_step(s, r);
        t++;
        #1;
        e = {m_out >= 0, 4'((m_out >= 0) ? m_out % 12 : 0), 2'((m_out >= 0) ? m_out / 12 : 0),
             m_chg, 13'(m_avg)};
        a = {note_vld, note_idx, note_oct, note_chg, period_avg};
        check("cycle {vld,idx,oct,chg,avg}", a, e);
        if (note_chg) chg_cnt++;
        if (first_avg < 0 && period_avg != 0) first_avg = t - 1 - t0;
    endtask

    // Square wave starting with the negative half; random amplitude per period and,
    // optionally, a random burst of sub-hysteresis noise at the start of the negative half.
    task automatic wave(input int period, input int nper, input bit noisy);
        int amp, nlen, s;
        for (int p = 0; p < nper; p++) begin
            amp  = int'($urandom_range(HYST, 3000));
            nlen = noisy ? int'($urandom_range(0, 40)) : 0;
            for (int i = 0; i < period; i++) begin
                s = (i < period / 2) ? -amp : amp;
                if (i < nlen) s = int'($urandom_range(0, 30)) - 15;
                tick(s, 1'b1);
            end
        end
    endtask

    typedef struct {
        int period;
        bit vld;
        int idx;
        int oct;
    } vec_t;

    vec_t tbl[3];
    longint saved_avg;

    initial begin
        tbl[0] = '{period: 1136, vld: 1'b1, idx: 9,  oct: 1};  // A5
        tbl[1] = '{period: 1012, vld: 1'b1, idx: 11, oct: 1};  // B5
        tbl[2] = '{period: 2400, vld: 1'b1, idx: 8,  oct: 0};  // inside the G#4 band

        tick(0, 1'b0);
        check("reset_vld", note_vld, 0);
        check("reset_avg", period_avg, 0);
        check("reset_chg", note_chg, 0);

        // A4 with noise near zero: first average after the 5th crossing, one change pulse
        chg_cnt = 0; first_avg = -1; t0 = t;
        wave(2272, 6, 1'b1);
        check("a4_first_avg_cycle", first_avg, 1136 + 4 * 2272);
        check("a4_avg", period_avg, 2272);
        check("a4_vld", note_vld, 1);
        check("a4_idx", note_idx, 9);
        check("a4_oct", note_oct, 0);
        check("a4_chg_count", chg_cnt, 1);

        foreach (tbl[i]) begin
            wave(tbl[i].period, 8, 1'b1);
            check("tbl_vld", note_vld, tbl[i].vld);
            check("tbl_idx", note_idx, tbl[i].idx);
            check("tbl_oct", note_oct, tbl[i].oct);
            check("tbl_avg", period_avg, tbl[i].period);
        end

        // Silence: counter saturates, note drops with one change pulse, average holds
        chg_cnt = 0;
        saved_avg = period_avg;
        for (int i = 0; i < SAT + 60; i++) tick(500, 1'b1);
        check("silence_vld", note_vld, 0);
        check("silence_idx", note_idx, 0);
        check("silence_oct", note_oct, 0);
        check("silence_chg_count", chg_cnt, 1);
        check("silence_avg_hold", period_avg, saved_avg);

        wave(1136, 4, 1'b0);
        check("resume_4x_avg_hold", period_avg, saved_avg);
        wave(1136, 2, 1'b0);
        check("resume_avg", period_avg, 1136);
        check("resume_vld", note_vld, 1);

        // Reset mid-window while a note is reported
        wave(1136, 2, 1'b0);
        tick(0, 1'b0);
        check("rst_vld", note_vld, 0);
        check("rst_idx", note_idx, 0);
        check("rst_oct", note_oct, 0);
        check("rst_chg", note_chg, 0);
        check("rst_avg", period_avg, 0);
        wave(955, 4, 1'b0);
        check("post_rst_4x_avg", period_avg, 0);
        wave(955, 2, 1'b0);
        check("post_rst_avg", period_avg, 955);
        check("c6_vld", note_vld, 1);
        check("c6_idx", note_idx, 0);
        check("c6_oct", note_oct, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
